xbar_rr_scheduler: RTL

Round-robin scheduler that shares the packet crossbar between its input ports. It accepts per-input transfer requests, each carrying a destination output and a beat length. It selects one winner at a time and emits a crossbar control word over a val/rdy handshake. It then holds the configuration until the requested number of beats has crossed, and only then arbitrates again. It sits beside the crossbar, driving the crossbar's control port.

---
 rtl/xbar_rr_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/xbar_rr_scheduler.sv
// Round-robin crossbar scheduler: grants one input at a time, issues a control word, then holds it for len+1 beats.
// Optional watchdog abort of a stalled transfer is enabled with `define XBAR_SCHED_TIMEOUT_EN.
module xbar_rr_scheduler #(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int ADDRESS_BIT_WIDTH = 4,
  parameter int BLOCK_ADDRESS     = 2,
  parameter int LEN_BITS          = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N_INPUTS-1:0]                     req_val,
  output logic [N_INPUTS-1:0]                     req_rdy,
  input  logic [N_INPUTS*$clog2(N_OUTPUTS)-1:0]   req_dest,
  input  logic [N_INPUTS*LEN_BITS-1:0]            req_len,
  output logic [CONTROL_BIT_WIDTH-1:0]            control_msg,
  output logic                                    control_val,
  input  logic                                    control_rdy,
  input  logic                                    beat_fire,
  output logic                                    busy,
  output logic [$clog2(N_INPUTS)-1:0]             grant_id,
  output logic                                    timeout_err
);

  localparam int IW_I = $clog2(N_INPUTS);
  localparam int IW_O = $clog2(N_OUTPUTS);
  localparam int CW   = CONTROL_BIT_WIDTH;
  localparam int AW   = ADDRESS_BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, CFG, XFER} state_t;

  state_t              state, state_next;
  logic [IW_I-1:0]     ptr;
  logic [LEN_BITS-1:0] cnt;
  logic [IW_I-1:0]     win;
  logic [IW_I-1:0]     idx;
  logic                any_req;
  logic                fire;
  logic                wd_expire;

  function automatic logic [CW-1:0] build_msg(input logic [IW_I-1:0] g, input logic [IW_O-1:0] d);
    logic [CW-1:0] m;
    m                        = '0;
    m[CW-1 -: AW]            = AW'(BLOCK_ADDRESS);
    m[CW-AW-1]               = 1'b1;
    m[CW-AW-2 -: IW_I]       = g;
    m[CW-AW-2-IW_I -: IW_O]  = d;
    return m;
  endfunction

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      idx = ptr + IW_I'(k);
      if (req_val[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (state == IDLE && any_req && !reset) req_rdy[win] = 1'b1;
  end

  assign fire        = |(req_val & req_rdy);
  assign control_val = (state == CFG);
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = CFG;
      CFG:     if (control_rdy) state_next = XFER;
      XFER: begin
        if (beat_fire && cnt == '0) state_next = IDLE;
        else if (wd_expire)         state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is sampled only on the clock edge and wins over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_id    <= '0;
      control_msg <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (fire) begin
          grant_id    <= win;
          cnt         <= req_len[int'(win)*LEN_BITS +: LEN_BITS];
          ptr         <= win + IW_I'(1);
          control_msg <= build_msg(win, req_dest[int'(win)*IW_O +: IW_O]);
        end
        XFER: if (beat_fire && cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef XBAR_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd;

  // Counter sits at zero outside XFER, so it is already clear on entry.
  assign wd_expire = (state == XFER) && !beat_fire && (wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != XFER || beat_fire) wd <= '0;
      else                            wd <= wd + 1'b1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
